// File: rtl/inert_intf_if.sv
// inert_intf_if: sensor/SPI handshake and pitch outputs shared by inert_intf and its environment
interface inert_intf_if;
  logic INT;
  logic done;
  logic [15:0] rd_data;
  logic wrt;
  logic [15:0] cmd;
  logic vld;
  logic signed [15:0] ptch_rt;
  logic signed [15:0] ptch;
  modport master (input INT, done, rd_data, output wrt, cmd, vld, ptch_rt, ptch);
  modport slave (output INT, done, rd_data, input wrt, cmd, vld, ptch_rt, ptch);
endinterface

// File: rtl/inert_intf.sv
// inert_intf: inertial sensor power-up init, pitch-rate reads and saturating pitch integration.
// Define PTCH_RT_OFFSET_EN to subtract RT_OFFSET (with 16-bit saturation) from each raw rate.
module inert_intf #(
  parameter logic [15:0] PWR_WAIT = 16'hFFFF,
  parameter logic [15:0] INIT_CMD0 = 16'h0D02,
  parameter logic [15:0] INIT_CMD1 = 16'h1062,
  parameter logic [15:0] INIT_CMD2 = 16'h1162,
  parameter logic [15:0] RD_CMD_L = 16'hA400,
  parameter logic [15:0] RD_CMD_H = 16'hA500,
  parameter logic signed [15:0] RT_OFFSET = 16'sh0040
) (
  input logic clk,
  input logic rst,
  inert_intf_if.master bus
);
  typedef enum logic [3:0] {PWR, INIT_WR, INIT_WT, IDLE, RDL_WR, RDL_WT, RDH_WR, RDH_WT, DONE} state_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [1:0] idx;
  logic [7:0] lo;
  logic int_m, int_s;
  logic signed [26:0] acc, acc_nxt;
  logic signed [27:0] sum;
  logic signed [15:0] raw, rt_new, rt_q;
  logic [15:0] cmd_q, nxt_cmd;
  logic wrt_q, vld_q;
  logic unused;
  assign unused = ^{bus.rd_data[15:8], RT_OFFSET};
  assign raw = {bus.rd_data[7:0], lo};
`ifdef PTCH_RT_OFFSET_EN
  logic [16:0] diff;
  assign diff = {raw[15], raw} - {RT_OFFSET[15], RT_OFFSET};
  assign rt_new = (diff[16] != diff[15]) ? (diff[16] ? 16'sh8000 : 16'sh7FFF) : diff[15:0];
`else
  assign rt_new = raw;
`endif
  // one guard bit above the 27-bit accumulator detects overflow for saturation
  assign sum = {acc[26], acc} + {{12{rt_new[15]}}, rt_new};
  assign acc_nxt = (sum[27] != sum[26]) ? (sum[27] ? 27'h4000000 : 27'h3FFFFFF) : sum[26:0];
  always_comb begin
    nxt = state;
    case (state)
      PWR: nxt = (cnt == PWR_WAIT) ? INIT_WR : PWR;
      INIT_WR: nxt = INIT_WT;
      INIT_WT: nxt = bus.done ? ((idx == 2'd2) ? IDLE : INIT_WR) : INIT_WT;
      IDLE: nxt = int_s ? RDL_WR : IDLE;
      RDL_WR: nxt = RDL_WT;
      RDL_WT: nxt = bus.done ? RDH_WR : RDL_WT;
      RDH_WR: nxt = RDH_WT;
      RDH_WT: nxt = bus.done ? DONE : RDH_WT;
      default: nxt = IDLE;
    endcase
  end
  // command is registered alongside wrt so it is already valid in the request cycle
  assign nxt_cmd = (nxt == INIT_WR) ? ((state == PWR) ? INIT_CMD0 : (idx == 2'd0) ? INIT_CMD1 : INIT_CMD2) :
                   (nxt == RDL_WR) ? RD_CMD_L : (nxt == RDH_WR) ? RD_CMD_H : cmd_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PWR;
      cnt <= '0;
      idx <= '0;
      lo <= '0;
      int_m <= 1'b0;
      int_s <= 1'b0;
      acc <= '0;
      rt_q <= '0;
      cmd_q <= '0;
      wrt_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      state <= nxt;
      int_m <= bus.INT;
      int_s <= int_m;
      cnt <= (state == PWR && nxt == PWR) ? cnt + 16'd1 : 16'd0;
      idx <= (state == PWR) ? 2'd0 : (state == INIT_WT && bus.done && idx != 2'd2) ? idx + 2'd1 : idx;
      lo <= (state == RDL_WT && bus.done) ? bus.rd_data[7:0] : lo;
      rt_q <= (nxt == DONE) ? rt_new : rt_q;
      acc <= (nxt == DONE) ? acc_nxt : acc;
      cmd_q <= nxt_cmd;
      wrt_q <= (nxt == INIT_WR || nxt == RDL_WR || nxt == RDH_WR);
      vld_q <= (nxt == DONE);
    end
  end
  assign bus.wrt = wrt_q;
  assign bus.cmd = cmd_q;
  assign bus.vld = vld_q;
  assign bus.ptch_rt = rt_q;
  assign bus.ptch = acc[26:11];
endmodule

// File: tb/tb_inert_intf.sv
// tb_inert_intf: randomized SPI/sensor responder with an arithmetic pitch-integration reference model
module tb_inert_intf;
  localparam logic [15:0] RD_L = 16'hA400;
  localparam logic [15:0] RD_H = 16'hA500;
  localparam longint AMAX = 67108863;
  localparam longint AMIN = -67108864;
  logic clk = 1'b0;
  logic rst = 1'b1;
  inert_intf_if bus();
  inert_intf #(.PWR_WAIT(16'h0010)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0, vld_cnt = 0, last_v = -100, hi_done_cyc = 0;
  int rd_idx = 0, wait_cnt = 0, spur_req = 0, spur_ack = 0;
  bit busy = 0, glitch = 0, fast = 0;
  logic [15:0] cur = 16'h0, cur_s;
  logic [15:0] log_q[$];
  logic [15:0] samp[$];
  longint m_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  // sensor + SPI slave: answers each wrt with a done after a latency, INT high while samples are pending
  initial begin
    bus.INT = 1'b0;
    bus.done = 1'b0;
    bus.rd_data = 16'h0;
    forever begin
      @(negedge clk);
      bus.done = 1'b0;
      if (bus.vld) begin
        vld_cnt++;
        if (cyc - last_v < 6) begin errors++; $display("FAIL vld_spacing gap=%0d required>=6", cyc - last_v); end
        last_v = cyc;
      end
      if (rst) busy = 0;
      else if (busy) begin
        if (bus.wrt) begin errors++; $display("FAIL wrt_outstanding cmd=%h while %h pending", bus.cmd, cur); end
        if (glitch && cur == RD_H) bus.INT = ~bus.INT;
        wait_cnt--;
        if (wait_cnt == 0) begin
          busy = 0;
          bus.done = 1'b1;
          cur_s = (rd_idx < samp.size()) ? samp[rd_idx] : 16'h0;
          bus.rd_data = {8'($urandom), (cur == RD_H) ? cur_s[15:8] : (cur == RD_L) ? cur_s[7:0] : 8'h00};
          if (cur == RD_H) begin rd_idx++; hi_done_cyc = cyc; end
        end
      end else if (bus.wrt) begin
        busy = 1;
        cur = bus.cmd;
        log_q.push_back(bus.cmd);
        wait_cnt = glitch ? 4 : fast ? 1 : int'($urandom_range(1, 3));
      end else if (spur_req != spur_ack && rd_idx >= samp.size()) begin
        bus.done = 1'b1;
        spur_ack++;
      end
      if (!(busy && glitch && cur == RD_H)) bus.INT = (rd_idx < samp.size());
    end
  end
  initial begin
    #950000;
    $display("FAIL watchdog expired before the test sequence finished");
    $fatal(1);
  end
  task automatic model(input logic [15:0] s, output logic [15:0] rt, output logic [15:0] p);
    longint v = longint'($signed(s));
`ifdef PTCH_RT_OFFSET_EN
    v = v - 64;
    v = (v < -32768) ? -32768 : (v > 32767) ? 32767 : v;
`endif
    rt = 16'(v);
    m_acc = m_acc + v;
    m_acc = (m_acc > AMAX) ? AMAX : (m_acc < AMIN) ? AMIN : m_acc;
    p = 16'(m_acc >>> 11);
  endtask
  task automatic wait_vld(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); ok = bus.vld; end
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt got=%b exp=0", bus.wrt); end
    if (bus.vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", bus.vld); end
    if (bus.cmd !== 16'h0) begin errors++; $display("FAIL reset_cmd got=%h exp=0000", bus.cmd); end
    if (bus.ptch_rt !== 16'h0) begin errors++; $display("FAIL reset_ptch_rt got=%h exp=0000", bus.ptch_rt); end
    if (bus.ptch !== 16'h0) begin errors++; $display("FAIL reset_ptch got=%h exp=0000", bus.ptch); end
  endtask
  task automatic test_init();
    int base;
    bit ok = 0;
    base = log_q.size();
    m_acc = 0;
    rst = 1'b0;
    repeat (16) @(negedge clk);
    checks++;
    if (bus.wrt !== 1'b0) begin errors++; $display("FAIL init_early_wrt got=%b exp=0 after 16 cycles", bus.wrt); end
    @(negedge clk);
    checks += 2;
    if (bus.wrt !== 1'b1) begin errors++; $display("FAIL init_first_wrt got=%b exp=1 after 17 cycles", bus.wrt); end
    if (bus.cmd !== 16'h0D02) begin errors++; $display("FAIL init_first_cmd got=%h exp=0D02", bus.cmd); end
    for (int i = 0; i < 100 && !ok; i++) begin @(negedge clk); #1; ok = (log_q.size() >= base + 3) && !busy; end
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout writes=%0d exp=3", log_q.size() - base); end
    else begin
      checks += 3;
      if (log_q[base] !== 16'h0D02) begin errors++; $display("FAIL init_cmd0 got=%h exp=0D02", log_q[base]); end
      if (log_q[base+1] !== 16'h1062) begin errors++; $display("FAIL init_cmd1 got=%h exp=1062", log_q[base+1]); end
      if (log_q[base+2] !== 16'h1162) begin errors++; $display("FAIL init_cmd2 got=%h exp=1162", log_q[base+2]); end
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_sample();
    logic [15:0] s, rt, p;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      s = (i == 0) ? 16'h1234 : (i == 1) ? 16'h8000 : 16'($urandom);
      samp.push_back(s);
      wait_vld(ok);
      model(s, rt, p);
      checks += 4;
      if (!ok) begin errors++; $display("FAIL sample_vld_timeout sample=%h", s); end
      if (cyc != hi_done_cyc + 1) begin errors++; $display("FAIL sample_vld_timing cycle=%0d exp=%0d", cyc, hi_done_cyc + 1); end
      if (bus.ptch_rt !== rt) begin errors++; $display("FAIL sample_ptch_rt got=%h exp=%h", bus.ptch_rt, rt); end
      if (bus.ptch !== p) begin errors++; $display("FAIL sample_ptch got=%h exp=%h", bus.ptch, p); end
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic test_spurious();
    int lc, vc;
    logic [15:0] s, rt, p;
    bit ok;
    lc = log_q.size();
    vc = vld_cnt;
    repeat (3) begin spur_req++; repeat (4) @(negedge clk); end
    repeat (10) @(negedge clk);
    checks += 2;
    if (log_q.size() != lc) begin errors++; $display("FAIL spurious_wrt got=%0d exp=0 extra writes", log_q.size() - lc); end
    if (vld_cnt != vc) begin errors++; $display("FAIL spurious_vld got=%0d exp=0 extra vld", vld_cnt - vc); end
    s = 16'($urandom);
    samp.push_back(s);
    wait_vld(ok);
    model(s, rt, p);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL spurious_follow_timeout sample=%h", s); end
    if (bus.ptch_rt !== rt) begin errors++; $display("FAIL spurious_follow_ptch_rt got=%h exp=%h", bus.ptch_rt, rt); end
  endtask
  task automatic test_int_glitch();
    int lc, vc;
    logic [15:0] s, rt, p;
    bit ok;
    repeat (4) @(negedge clk);
    lc = log_q.size();
    vc = vld_cnt;
    glitch = 1;
    s = 16'($urandom);
    samp.push_back(s);
    wait_vld(ok);
    model(s, rt, p);
    repeat (20) @(negedge clk);
    glitch = 0;
    checks += 5;
    if (!ok) begin errors++; $display("FAIL glitch_vld_timeout sample=%h", s); end
    if (bus.ptch_rt !== rt) begin errors++; $display("FAIL glitch_ptch_rt got=%h exp=%h", bus.ptch_rt, rt); end
    if (bus.ptch !== p) begin errors++; $display("FAIL glitch_ptch got=%h exp=%h", bus.ptch, p); end
    if (log_q.size() - lc != 2) begin errors++; $display("FAIL glitch_writes got=%0d exp=2", log_q.size() - lc); end
    if (vld_cnt - vc != 1) begin errors++; $display("FAIL glitch_vld_count got=%0d exp=1", vld_cnt - vc); end
  endtask
  task automatic test_reset_mid();
    int vc;
    logic [15:0] s, rt, p;
    bit ok, found = 0;
    s = 16'($urandom);
    samp.push_back(s);
    for (int i = 0; i < 300 && !found; i++) begin @(negedge clk); #1; found = busy && cur == RD_L; end
    checks++;
    if (!found) begin errors++; $display("FAIL midrst_no_low_read got=0 exp=1"); end
    rst = 1'b1;
    #1;
    checks += 5;
    if (bus.wrt !== 1'b0) begin errors++; $display("FAIL midrst_wrt got=%b exp=0", bus.wrt); end
    if (bus.vld !== 1'b0) begin errors++; $display("FAIL midrst_vld got=%b exp=0", bus.vld); end
    if (bus.cmd !== 16'h0) begin errors++; $display("FAIL midrst_cmd got=%h exp=0000", bus.cmd); end
    if (bus.ptch_rt !== 16'h0) begin errors++; $display("FAIL midrst_ptch_rt got=%h exp=0000", bus.ptch_rt); end
    if (bus.ptch !== 16'h0) begin errors++; $display("FAIL midrst_ptch got=%h exp=0000", bus.ptch); end
    vc = vld_cnt;
    @(negedge clk);
    @(negedge clk);
    test_init();
    checks++;
    if (vld_cnt != vc) begin errors++; $display("FAIL midrst_vld_during_reinit got=%0d exp=0", vld_cnt - vc); end
    wait_vld(ok);
    model(s, rt, p);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL midrst_resample_timeout sample=%h", s); end
    if (bus.ptch_rt !== rt) begin errors++; $display("FAIL midrst_ptch_rt got=%h exp=%h", bus.ptch_rt, rt); end
    if (bus.ptch !== p) begin errors++; $display("FAIL midrst_ptch got=%h exp=%h", bus.ptch, p); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] rt, p;
    bit ok;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_init();
    repeat (10) samp.push_back(16'h7FFF);
    for (int i = 0; i < 10; i++) begin
      wait_vld(ok);
      model(16'h7FFF, rt, p);
      checks += 3;
      if (!ok) begin errors++; $display("FAIL b2b_vld_timeout index=%0d", i); end
      if (bus.ptch_rt !== rt) begin errors++; $display("FAIL b2b_ptch_rt got=%h exp=%h", bus.ptch_rt, rt); end
      if (bus.ptch !== p) begin errors++; $display("FAIL b2b_ptch got=%h exp=%h", bus.ptch, p); end
    end
    checks++;
    if (bus.ptch !== 16'h009F) begin errors++; $display("FAIL b2b_ptch_after_ten got=%h exp=009F", bus.ptch); end
  endtask
  task automatic test_saturation();
    logic [15:0] s, rt, p;
    bit ok;
    fast = 1;
    for (int ph = 0; ph < 2; ph++) begin
      s = (ph == 0) ? 16'h7FFF : 16'h8000;
      repeat ((ph == 0) ? 2100 : 4150) samp.push_back(s);
      for (int i = 0; i < ((ph == 0) ? 2100 : 4150); i++) begin
        wait_vld(ok);
        model(s, rt, p);
        checks += 2;
        if (!ok) begin errors++; $display("FAIL sat_vld_timeout phase=%0d index=%0d", ph, i); end
        if (bus.ptch !== p) begin errors++; $display("FAIL sat_ptch phase=%0d got=%h exp=%h", ph, bus.ptch, p); end
      end
      checks++;
      if (bus.ptch !== ((ph == 0) ? 16'h7FFF : 16'h8000)) begin
        errors++; $display("FAIL sat_pinned phase=%0d got=%h exp=%h", ph, bus.ptch, (ph == 0) ? 16'h7FFF : 16'h8000);
      end
    end
    fast = 0;
  endtask
  initial begin
    test_reset();
    test_init();
    test_sample();
    test_spurious();
    test_int_glitch();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
